// File: rtl/pipe_pkg.sv
// Types and constants shared by the pipeline stages: writeback source select,
// load funct3 encodings and the writeback-stage state encoding.
package pipe_pkg;

  typedef enum logic [1:0] {
    WB_ALU  = 2'd0,
    WB_LOAD = 2'd1,
    WB_PC4  = 2'd2,
    WB_NONE = 2'd3
  } wb_sel_e;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [1:0] {
    StEmpty    = 2'd0,
    StWrite    = 2'd1,
    StWaitLoad = 2'd2,
    StLoadDone = 2'd3
  } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Combinational load formatter: picks the byte/halfword addressed by the offset
// out of the aligned memory word and sign- or zero-extends it.
module load_align
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (offset_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Any encoding outside the five loads is treated as a full-word load.
  always_comb begin
    case (funct3_i)
      F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB stage: holds one retiring instruction, waits for load data, and drives
// the register file write port plus forwarding, pending-load and instret info.
module writeback_stage
  import pipe_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_rd,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [2:0]       in_ld_f3,
  input  logic             dmem_rvalid,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             reg_we,
  output logic [4:0]       reg_waddr,
  output logic [XLEN-1:0]  reg_wdata,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic             ld_pend,
  output logic [4:0]       ld_pend_rd,
  output logic [CNT_W-1:0] instret
);

  wb_state_e        state_q;
  wb_sel_e          wb_sel_q;
  logic [4:0]       rd_q;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic [XLEN-1:0]  data_q;
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  ld_data;
  wb_sel_e          in_sel;
  logic             retiring;

  assign in_sel   = wb_sel_e'(in_wb_sel);
  assign in_ready = (state_q != StWaitLoad);
  assign retiring = (state_q == StWrite) || (state_q == StLoadDone);

  load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .funct3_i(f3_q),
    .offset_i(off_q),
    .rdata_i (dmem_rdata),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StEmpty;
      wb_sel_q  <= WB_NONE;
      rd_q      <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      data_q    <= '0;
      instret_q <= '0;
    end else begin
      // Each WRITE/LOAD_DONE cycle retires exactly one instruction.
      if (retiring) instret_q <= instret_q + CNT_W'(1);
      if (state_q == StWaitLoad) begin
        if (dmem_rvalid) begin
          data_q  <= ld_data;
          state_q <= StLoadDone;
        end
      end else if (in_valid) begin
        rd_q     <= in_rd;
        wb_sel_q <= in_sel;
        if (in_sel == WB_LOAD) begin
          f3_q    <= in_ld_f3;
          off_q   <= in_alu[1:0];
          state_q <= StWaitLoad;
        end else begin
          data_q  <= (in_sel == WB_PC4) ? in_pc4 : in_alu;
          state_q <= StWrite;
        end
      end else begin
        state_q <= StEmpty;
      end
    end
  end

  assign reg_we     = retiring && (rd_q != 5'd0) && (wb_sel_q != WB_NONE);
  assign reg_waddr  = rd_q;
  assign reg_wdata  = data_q;
  assign fwd_valid  = reg_we;
  assign fwd_rd     = reg_waddr;
  assign fwd_data   = reg_wdata;
  assign ld_pend    = (state_q == StWaitLoad);
  assign ld_pend_rd = rd_q;
  assign instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: stimulus pushes expected writes into a
// queue, a negedge monitor pops and compares whenever reg_we is seen.
module tb_writeback_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [4:0]       in_rd = '0;
  logic [1:0]       in_wb_sel = '0;
  logic [XLEN-1:0]  in_alu = '0;
  logic [XLEN-1:0]  in_pc4 = '0;
  logic [2:0]       in_ld_f3 = '0;
  logic             dmem_rvalid = 1'b0;
  logic [XLEN-1:0]  dmem_rdata = '0;
  logic             reg_we;
  logic [4:0]       reg_waddr;
  logic [XLEN-1:0]  reg_wdata;
  logic             fwd_valid;
  logic [4:0]       fwd_rd;
  logic [XLEN-1:0]  fwd_data;
  logic             ld_pend;
  logic [4:0]       ld_pend_rd;
  logic [CNT_W-1:0] instret;

  int  n_pass = 0;
  int  n_total = 0;
  int  exp_instret = 0;
  wr_t exp_q[$];

  writeback_stage #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_wb_sel  (in_wb_sel),
    .in_alu     (in_alu),
    .in_pc4     (in_pc4),
    .in_ld_f3   (in_ld_f3),
    .dmem_rvalid(dmem_rvalid),
    .dmem_rdata (dmem_rdata),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .fwd_valid  (fwd_valid),
    .fwd_rd     (fwd_rd),
    .fwd_data   (fwd_data),
    .ld_pend    (ld_pend),
    .ld_pend_rd (ld_pend_rd),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every observed write must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      chk("fwd_valid", 32'(fwd_valid), 32'(reg_we));
      if (reg_we) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got rd %0d data %h expected no write at %0t",
                   reg_waddr, reg_wdata, $time);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("reg_waddr", 32'(reg_waddr), 32'(e.rd));
          chk("reg_wdata", reg_wdata, e.data);
          chk("fwd_rd", 32'(fwd_rd), 32'(e.rd));
          chk("fwd_data", fwd_data, e.data);
        end
      end
    end
  end

  task automatic op(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                    input logic [31:0] pc4, input bit wr, input logic [31:0] wdata);
    @(negedge clk);
    chk("in_ready_op", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_rd     = rd;
    in_wb_sel = sel;
    in_alu    = alu;
    in_pc4    = pc4;
    if (wr) exp_q.push_back('{rd: rd, data: wdata});
    exp_instret++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic ld(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                    input logic [31:0] rdata, input logic [31:0] wdata, input int wait_cyc);
    @(negedge clk);
    chk("in_ready_ld", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    in_rd     = rd;
    in_wb_sel = 2'd1;
    in_ld_f3  = f3;
    in_alu    = {30'h1000_0000, off};
    exp_q.push_back('{rd: rd, data: wdata});
    exp_instret++;
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int i = 0; i < wait_cyc; i++) begin
      @(negedge clk);
      chk("ld_pend", 32'(ld_pend), 32'd1);
      chk("in_ready_wait", 32'(in_ready), 32'd0);
      chk("ld_pend_rd", 32'(ld_pend_rd), 32'(rd));
      if (i == wait_cyc - 1) begin
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
      end
    end
    @(posedge clk);
    #1 dmem_rvalid = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("instret", instret, 32'(exp_instret));
    chk("ld_pend_idle", 32'(ld_pend), 32'd0);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_reg_we", 32'(reg_we), 32'd0);
    chk("rst_reg_waddr", 32'(reg_waddr), 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    chk("rst_ld_pend", 32'(ld_pend), 32'd0);
    chk("rst_ld_pend_rd", 32'(ld_pend_rd), 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    op(5'd5, 2'd0, 32'h0000_1234, 32'h0, 1'b1, 32'h0000_1234);
    drain();

    // Back-to-back ALU ops, then a PC+4 op.
    op(5'd1, 2'd0, 32'h1111_0001, 32'h0, 1'b1, 32'h1111_0001);
    op(5'd2, 2'd0, 32'h2222_0002, 32'h0, 1'b1, 32'h2222_0002);
    op(5'd3, 2'd0, 32'h3333_0003, 32'h0, 1'b1, 32'h3333_0003);
    op(5'd9, 2'd2, 32'hDEAD_BEEF, 32'h0000_0104, 1'b1, 32'h0000_0104);
    drain();

    ld(5'd10, 3'd0, 2'd3, 32'h80FF_FF7F, 32'hFFFF_FF80, 3);
    ld(5'd11, 3'd4, 2'd3, 32'h80FF_FF7F, 32'h0000_0080, 3);
    ld(5'd12, 3'd0, 2'd0, 32'h80FF_FF7F, 32'h0000_007F, 1);
    ld(5'd13, 3'd1, 2'd2, 32'h8001_0000, 32'hFFFF_8001, 1);
    ld(5'd14, 3'd5, 2'd3, 32'h8001_0000, 32'h0000_8001, 2);
    ld(5'd15, 3'd2, 2'd2, 32'h8001_0000, 32'h8001_0000, 1);
    ld(5'd16, 3'd1, 2'd1, 32'h8001_8002, 32'hFFFF_8002, 1);
    ld(5'd17, 3'd3, 2'd1, 32'h8001_8002, 32'h8001_8002, 1);
    // Load directly followed by an ALU op, then no-write retirements.
    op(5'd20, 2'd0, 32'h0BAD_F00D, 32'h0, 1'b1, 32'h0BAD_F00D);
    drain();

    op(5'd0, 2'd0, 32'h5555_5555, 32'h0, 1'b0, 32'h0);
    op(5'd7, 2'd3, 32'h6666_6666, 32'h0, 1'b0, 32'h0);
    drain();

    // Reset in the middle of a load drops it; a later rvalid is ignored.
    @(negedge clk);
    in_valid  = 1'b1;
    in_rd     = 5'd21;
    in_wb_sel = 2'd1;
    in_ld_f3  = 3'd2;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("mid_ld_pend", 32'(ld_pend), 32'd1);
    #1 rst = 1'b1;
    #2;
    chk("async_ld_pend", 32'(ld_pend), 32'd0);
    chk("async_in_ready", 32'(in_ready), 32'd1);
    chk("async_instret", instret, 32'd0);
    #1 rst = 1'b0;
    exp_instret = 0;
    @(negedge clk);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hCAFE_CAFE;
    @(posedge clk);
    #1 dmem_rvalid = 1'b0;
    drain();
    chk("stale_reg_we", 32'(reg_we), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
